// File: rtl/mdu_pkg.sv
// mdu_pkg: shared op encodings, FSM states and decode helpers for the iterative MDU
package mdu_pkg;
  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;
  localparam int IS_DIV = 2;
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
endpackage

// File: rtl/mdu_addsub.sv
// mdu_addsub: W-bit adder/subtractor; on subtract co=1 means no borrow (x >= y)
module mdu_addsub #(
  parameter int W = 8
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         sub,
  output logic [W-1:0] s,
  output logic         co
);
  assign {co, s} = {1'b0, x} + {1'b0, sub ? ~y : y} + {{W{1'b0}}, sub};
endmodule

// File: rtl/mdu_iter.sv
// mdu_iter: iterative RV32M multiply/divide unit with valid/ready handshake and kill
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             kill,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  state_t state, state_nx;
  logic [2:0] op_r;
  logic sign_a, sign_b;
  logic [WIDTH-1:0] opnd;
  logic [2*WIDTH-1:0] acc, step_acc;
  logic [CW-1:0] cnt;
  logic accept, sa_in, sb_in, zero_div, ovf, fast;
  logic [WIDTH-1:0] abs_a, abs_b, fast_res, fix_res;
  logic [WIDTH:0] step_x, step_s;
  logic step_co;
  logic [2*WIDTH-1:0] neg_in, neg_out, fixed;
  logic neg_sel, neg_co;

  assign in_ready = state == IDLE;
  assign accept   = in_valid && state == IDLE;
  assign sa_in    = a[WIDTH-1] && (op == OP_MULH || op == OP_MULHSU || op == OP_DIV || op == OP_REM);
  assign sb_in    = b[WIDTH-1] && (op == OP_MULH || op == OP_DIV || op == OP_REM);
  assign abs_a    = sa_in ? -a : a;
  assign abs_b    = sb_in ? -b : b;
  assign zero_div = op[IS_DIV] && b == '0;
  assign ovf      = op[IS_DIV] && !op[0] && a == {1'b1, {(WIDTH-1){1'b0}}} && &b;
  assign fast     = zero_div || ovf;
  assign fast_res = zero_div ? (op[1] ? a : '1) : (op[1] ? '0 : a);

  // Multiply adds the multiplicand into the high half; divide trial-subtracts the divisor
  // from the shifted partial remainder. Both share the one WIDTH+1 adder.
  assign step_x   = op_r[IS_DIV] ? acc[2*WIDTH-1:WIDTH-1] : {1'b0, acc[2*WIDTH-1:WIDTH]};
  assign step_acc = op_r[IS_DIV]
                  ? (step_co ? {step_s[WIDTH-1:0], acc[WIDTH-2:0], 1'b1} : {acc[2*WIDTH-2:0], 1'b0})
                  : (acc[0] ? {step_s, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]});

  mdu_addsub #(.W(WIDTH + 1)) u_step (
    .x  (step_x),
    .y  ({1'b0, opnd}),
    .sub(op_r[IS_DIV]),
    .s  (step_s),
    .co (step_co)
  );

  // Divide leaves remainder in the high half and quotient in the low half
  assign neg_in  = op_r[IS_DIV] ? {{WIDTH{1'b0}}, op_r[1] ? acc[2*WIDTH-1:WIDTH] : acc[WIDTH-1:0]} : acc;
  assign neg_sel = (op_r[IS_DIV] && op_r[1]) ? sign_a : sign_a ^ sign_b;

  mdu_addsub #(.W(2 * WIDTH)) u_neg (
    .x  ('0),
    .y  (neg_in),
    .sub(1'b1),
    .s  (neg_out),
    .co (neg_co)
  );

  assign fixed   = (neg_sel && !neg_co) ? neg_out : neg_in;
  assign fix_res = (!op_r[IS_DIV] && op_r != OP_MUL) ? fixed[2*WIDTH-1:WIDTH] : fixed[WIDTH-1:0];

  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_nx;

  always_comb begin
    state_nx = state;
    if (state == IDLE) state_nx = in_valid ? (fast ? DONE : CALC) : IDLE;
    else if (kill) state_nx = IDLE;
    else if (state == CALC) state_nx = cnt == LAST ? FIX : CALC;
    else if (state == FIX) state_nx = DONE;
    else state_nx = out_ready ? IDLE : DONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_r      <= '0;
      sign_a    <= 1'b0;
      sign_b    <= 1'b0;
      opnd      <= '0;
      acc       <= '0;
      cnt       <= '0;
      result    <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= state_nx == DONE;
      if (accept) begin
        op_r   <= op;
        sign_a <= sa_in;
        sign_b <= sb_in;
        opnd   <= op[IS_DIV] ? abs_b : abs_a;
        acc    <= {{WIDTH{1'b0}}, op[IS_DIV] ? abs_a : abs_b};
        cnt    <= '0;
        if (fast) result <= fast_res;
      end else if (state == CALC) begin
        acc <= step_acc;
        cnt <= cnt + 1'b1;
      end else if (state == FIX && !kill) begin
        result <= fix_res;
      end
    end
  end
endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: randomized and directed checks of mdu_iter at WIDTH=32 and exhaustive at WIDTH=4
module tb_mdu_iter;
  import mdu_pkg::*;
  logic clk = 1'b0;
  logic rst;
  logic in_valid, kill, out_ready, in_ready, out_valid;
  logic [2:0] op;
  logic [31:0] a, b, result;
  logic in_valid4, kill4, out_ready4, in_ready4, out_valid4;
  logic [2:0] op4;
  logic [3:0] a4, b4, result4;
  int n_chk = 0;
  int n_fail = 0;

  mdu_iter #(.WIDTH(32)) u32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
    .kill(kill), .out_valid(out_valid), .out_ready(out_ready), .result(result)
  );

  mdu_iter #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4), .op(op4), .a(a4), .b(b4),
    .kill(kill4), .out_valid(out_valid4), .out_ready(out_ready4), .result(result4)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference model: exact integer arithmetic in 128 bits, then reduced modulo 2^w
  function automatic logic [31:0] model(input int w, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    logic signed [127:0] xs, ys, xu, yu, r, one;
    logic [31:0] m;
    one = 128'sd1;
    m = (w == 32) ? 32'hFFFF_FFFF : (32'd1 << w) - 32'd1;
    xu = $signed({96'd0, x & m});
    yu = $signed({96'd0, y & m});
    xs = x[w-1] ? xu - (one <<< w) : xu;
    ys = y[w-1] ? yu - (one <<< w) : yu;
    case (o)
      OP_MUL:    r = xu * yu;
      OP_MULH:   r = (xs * ys) >>> w;
      OP_MULHSU: r = (xs * yu) >>> w;
      OP_MULHU:  r = (xu * yu) >>> w;
      OP_DIV:    r = (yu == 0) ? -one : xs / ys;
      OP_DIVU:   r = (yu == 0) ? -one : xu / yu;
      OP_REM:    r = (yu == 0) ? xs : xs % ys;
      default:   r = (yu == 0) ? xu : xu % yu;
    endcase
    return r[31:0] & m;
  endfunction

  task automatic run32(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       output int lat, output logic [31:0] res, output logic busy_ok);
    busy_ok = 1'b1;
    op = o; a = x; b = y; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      if (in_ready) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (in_ready) busy_ok = 1'b0;
    res = result;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_chk += 4;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    if (result !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h expected 0", result); end
    if (in_ready4 !== 1'b1 || out_valid4 !== 1'b0 || result4 !== 4'h0) begin
      n_fail++; $display("FAIL reset_w4: got ready=%b valid=%b result=%h expected 1 0 0", in_ready4, out_valid4, result4);
    end
  endtask

  logic [2:0]  d_op  [12] = '{OP_MUL, OP_MULH, OP_MULHU, OP_MULHSU, OP_DIV, OP_REM,
                              OP_DIVU, OP_REMU, OP_DIV, OP_REMU, OP_DIV, OP_REM};
  logic [31:0] d_a   [12] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                              32'd100, 32'd100, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
  logic [31:0] d_b   [12] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd2,
                              32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
  logic [31:0] d_exp [12] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
                              32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
  int          d_lat [12] = '{34, 34, 34, 34, 34, 34, 34, 34, 1, 1, 1, 1};

  task automatic test_directed();
    int lat;
    logic [31:0] res;
    logic busy_ok;
    for (int i = 0; i < 12; i++) begin
      run32(d_op[i], d_a[i], d_b[i], lat, res, busy_ok);
      n_chk += 4;
      if (res !== d_exp[i]) begin n_fail++; $display("FAIL directed_result[%0d]: got %h expected %h", i, res, d_exp[i]); end
      if (lat != d_lat[i]) begin n_fail++; $display("FAIL directed_latency[%0d]: got %0d expected %0d", i, lat, d_lat[i]); end
      if (!busy_ok) begin n_fail++; $display("FAIL directed_busy[%0d]: in_ready got 1 expected 0 while busy", i); end
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL directed_idle[%0d]: in_ready got %b expected 1", i, in_ready); end
    end
  endtask

  task automatic test_hold();
    logic [31:0] exp;
    int t;
    exp = model(32, OP_MULHU, 32'hDEAD_BEEF, 32'h1234_5678);
    op = OP_MULHU; a = 32'hDEAD_BEEF; b = 32'h1234_5678; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    t = 0;
    while (!out_valid && t < 100) begin @(negedge clk); t++; end
    for (int i = 0; i < 5; i++) begin
      n_chk++;
      if (out_valid !== 1'b1 || result !== exp || in_ready !== 1'b0) begin
        n_fail++; $display("FAIL hold[%0d]: got valid=%b ready=%b result=%h expected 1 0 %h", i, out_valid, in_ready, result, exp);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_chk++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL hold_release: got ready=%b valid=%b expected 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_kill();
    logic seen;
    op = OP_DIVU; a = 32'd123456; b = 32'd789; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    n_chk++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL kill_calc: got valid=%b ready=%b expected 0 1", out_valid, in_ready);
    end
    seen = 1'b0;
    repeat (36) begin @(negedge clk); if (out_valid) seen = 1'b1; end
    n_chk++;
    if (seen) begin n_fail++; $display("FAIL kill_no_result: out_valid got 1 expected 0 after kill"); end
  endtask

  task automatic test_rst_fix();
    op = OP_MUL; a = 32'd99; b = 32'd77; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (32) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_chk++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL rst_fix: got valid=%b ready=%b expected 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_kill_idle_accept();
    int t;
    op = OP_DIVU; a = 32'd1000; b = 32'd3; in_valid = 1'b1; kill = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; kill = 1'b0;
    n_chk++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL kill_idle_accept: in_ready got %b expected 0", in_ready); end
    t = 0;
    while (!out_valid && t < 100) begin @(negedge clk); t++; end
    n_chk++;
    if (out_valid !== 1'b1 || result !== 32'd333) begin
      n_fail++; $display("FAIL kill_idle_result: got valid=%b result=%h expected 1 %h", out_valid, result, 32'd333);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [31:0] res, x, y;
    logic busy_ok;
    logic [2:0] o;
    for (int i = 0; i < 8; i++) begin
      o = 3'(i); x = $urandom; y = $urandom;
      run32(o, x, y, lat, res, busy_ok);
      n_chk += 2;
      if (res !== model(32, o, x, y)) begin n_fail++; $display("FAIL b2b_result[%0d]: got %h expected %h", i, res, model(32, o, x, y)); end
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready[%0d]: in_ready got %b expected 1", i, in_ready); end
    end
  endtask

  task automatic test_random();
    logic [2:0] o;
    logic [31:0] x, y, exp;
    int kill_at, stall, c;
    logic done;
    for (int n = 0; n < 1000; n++) begin
      o = 3'($urandom_range(0, 7));
      x = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      y = ($urandom_range(0, 7) == 0) ? 32'h0 : ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
      exp = model(32, o, x, y);
      kill_at = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 40)) : -1;
      stall = $urandom_range(0, 3);
      op = o; a = x; b = y; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      c = 0;
      done = 1'b0;
      while (!done) begin
        if (c == kill_at) begin
          kill = 1'b1;
          @(negedge clk);
          kill = 1'b0;
          n_chk++;
          if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL rand_kill[%0d]: got valid=%b ready=%b expected 0 1", n, out_valid, in_ready);
          end
          done = 1'b1;
        end else if (out_valid && stall == 0) begin
          n_chk++;
          if (result !== exp) begin n_fail++; $display("FAIL rand_result[%0d] op=%0d a=%h b=%h: got %h expected %h", n, o, x, y, result, exp); end
          out_ready = 1'b1;
          @(negedge clk);
          out_ready = 1'b0;
          n_chk++;
          if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rand_idle[%0d]: in_ready got %b expected 1", n, in_ready); end
          done = 1'b1;
        end else begin
          if (out_valid) stall--;
          @(negedge clk);
          c++;
          if (c > 200) begin
            n_chk++; n_fail++;
            $display("FAIL rand_timeout[%0d]: out_valid got 0 expected 1 within 200 cycles", n);
            rst = 1'b1; @(negedge clk); rst = 1'b0;
            done = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic test_exhaustive4();
    logic [31:0] exp;
    int lat, want;
    logic fast;
    for (int o = 0; o < 8; o++)
      for (int x = 0; x < 16; x++)
        for (int y = 0; y < 16; y++) begin
          exp = model(4, 3'(o), 32'(x), 32'(y));
          fast = (o >= 4) && (y == 0 || ((o == 4 || o == 6) && x == 8 && y == 15));
          want = fast ? 1 : 6;
          op4 = 3'(o); a4 = 4'(x); b4 = 4'(y); in_valid4 = 1'b1;
          @(negedge clk);
          in_valid4 = 1'b0;
          lat = 1;
          while (!out_valid4 && lat < 50) begin @(negedge clk); lat++; end
          n_chk += 2;
          if ({28'd0, result4} !== exp) begin n_fail++; $display("FAIL w4_result op=%0d a=%0d b=%0d: got %h expected %h", o, x, y, result4, exp[3:0]); end
          if (lat != want) begin n_fail++; $display("FAIL w4_latency op=%0d a=%0d b=%0d: got %0d expected %0d", o, x, y, lat, want); end
          out_ready4 = 1'b1;
          @(negedge clk);
          out_ready4 = 1'b0;
        end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; kill = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
    in_valid4 = 1'b0; kill4 = 1'b0; out_ready4 = 1'b0; op4 = '0; a4 = '0; b4 = '0;
    test_reset();
    test_directed();
    test_hold();
    test_kill();
    test_rst_fix();
    test_kill_idle_accept();
    test_back_to_back();
    test_random();
    test_exhaustive4();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
